// File: rtl/user_input_pkg.sv
// Shared constants for the user-input interrupt controller: register map,
// bus width and configuration reset values.
package user_input_pkg;

    localparam int AVL_DATA_W = 32;
    localparam int AVL_ADDR_W = 3;

    localparam logic [AVL_ADDR_W-1:0] ADDR_STATE   = 3'd0;
    localparam logic [AVL_ADDR_W-1:0] ADDR_PENDING = 3'd1;
    localparam logic [AVL_ADDR_W-1:0] ADDR_MASK    = 3'd2;
    localparam logic [AVL_ADDR_W-1:0] ADDR_RISE_EN = 3'd3;
    localparam logic [AVL_ADDR_W-1:0] ADDR_FALL_EN = 3'd4;

    localparam logic [AVL_DATA_W-1:0] RISE_EN_RST = '1;
    localparam logic [AVL_DATA_W-1:0] FALL_EN_RST = '0;

endpackage

// File: rtl/user_input_irq_ctrl_debouncer.sv
// Single-channel debouncer: dout follows din only after din has differed
// from dout for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/user_input_irq_ctrl.sv
// Avalon-MM user-input controller with per-channel edge interrupts.
// Define USER_INPUT_DEBOUNCE_EN to insert a debouncer after each synchroniser.
module user_input_irq_ctrl
    import user_input_pkg::*;
#(
    parameter int NUM_INPUTS      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] inputs,
    input  logic [2:0]            avl_address,
    input  logic                  avl_read,
    input  logic                  avl_write,
    input  logic [31:0]           avl_writedata,
    output logic [31:0]           avl_readdata,
    output logic                  avl_irq_n
);

    logic [NUM_INPUTS-1:0] sync1, sync2, deb, deb_d;
    logic [NUM_INPUTS-1:0] rise, fall, clr;
    logic [NUM_INPUTS-1:0] pending, irq_mask, rise_en, fall_en;
    logic [NUM_INPUTS-1:0] wdata;
    logic [AVL_DATA_W-1:0] rd_mux;

    assign wdata = avl_writedata[NUM_INPUTS-1:0];

    generate
        if (NUM_INPUTS < AVL_DATA_W) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^avl_writedata[AVL_DATA_W-1:NUM_INPUTS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= inputs;
            sync2 <= sync1;
        end
    end

`ifdef USER_INPUT_DEBOUNCE_EN
    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
            input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk   (clk),
                .reset (reset),
                .din   (sync2[i]),
                .dout  (deb[i])
            );
        end
    endgenerate
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign deb = sync2;
`endif

    // deb_d resets to 0, so an input held high through reset still yields a rise.
    always_ff @(posedge clk) begin
        if (reset) deb_d <= '0;
        else       deb_d <= deb;
    end

    assign rise = deb & ~deb_d;
    assign fall = ~deb & deb_d;
    assign clr  = (avl_write && avl_address == ADDR_PENDING) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            irq_mask <= '0;
            rise_en  <= RISE_EN_RST[NUM_INPUTS-1:0];
            fall_en  <= FALL_EN_RST[NUM_INPUTS-1:0];
        end else begin
            // New edges are ORed in after the clear so a set wins a W1C race.
            pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);
            if (avl_write) begin
                case (avl_address)
                    ADDR_MASK:    irq_mask <= wdata;
                    ADDR_RISE_EN: rise_en  <= wdata;
                    ADDR_FALL_EN: fall_en  <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avl_address)
            ADDR_STATE:   rd_mux[NUM_INPUTS-1:0] = deb;
            ADDR_PENDING: rd_mux[NUM_INPUTS-1:0] = pending;
            ADDR_MASK:    rd_mux[NUM_INPUTS-1:0] = irq_mask;
            ADDR_RISE_EN: rd_mux[NUM_INPUTS-1:0] = rise_en;
            ADDR_FALL_EN: rd_mux[NUM_INPUTS-1:0] = fall_en;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)         avl_readdata <= '0;
        else if (avl_read) avl_readdata <= rd_mux;
    end

    assign avl_irq_n = ~|(pending & irq_mask);

endmodule

// File: tb/tb_user_input_irq_ctrl.sv
// Scoreboard bench for user_input_irq_ctrl: stimulus queues expected read data
// and IRQ levels; a monitor compares them as the DUT presents results.
module tb_user_input_irq_ctrl;

    localparam int N = 8;
`ifdef USER_INPUT_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif
    localparam int L = 2 + D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [N-1:0] inputs = '0;
    logic [2:0]  avl_address = '0;
    logic        avl_read = 1'b0;
    logic        avl_write = 1'b0;
    logic [31:0] avl_writedata = '0;
    logic [31:0] avl_readdata;
    logic        avl_irq_n;
    logic        irq_chk = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic rd_seen = 1'b0;
    logic irq_seen = 1'b0;

    user_input_irq_ctrl #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .inputs        (inputs),
        .avl_address   (avl_address),
        .avl_read      (avl_read),
        .avl_write     (avl_write),
        .avl_writedata (avl_writedata),
        .avl_readdata  (avl_readdata),
        .avl_irq_n     (avl_irq_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_seen  <= avl_read;
        irq_seen <= irq_chk;
    end

    // Monitor: one result per cycle, either registered read data or the IRQ level.
    always @(negedge clk) begin
        if (rd_seen || irq_seen) begin
            logic [31:0] act;
            exp_t e;
            act = rd_seen ? avl_readdata : {31'b0, avl_irq_n};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_result: got 0x%08h with nothing expected", act);
            end else begin
                e = exp_q.pop_front();
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        avl_read  = 1'b0;
        avl_write = 1'b0;
        irq_chk   = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        avl_address = a;
        avl_read    = 1'b1;
        exp_q.push_back('{nm, e});
        step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avl_address   = a;
        avl_write     = 1'b1;
        avl_writedata = d;
        step();
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e,
                        input string nm);
        avl_address   = a;
        avl_read      = 1'b1;
        avl_write     = 1'b1;
        avl_writedata = d;
        exp_q.push_back('{nm, e});
        step();
    endtask

    task automatic chk_irq(input logic e, input string nm);
        irq_chk = 1'b1;
        exp_q.push_back('{nm, {31'b0, e}});
        step();
    endtask

    initial begin
        steps(3);
        reset = 1'b0;

        // reset values
        rd(3'd3, 32'h0000_00FF, "rst_rise_en");
        rd(3'd1, 32'h0, "rst_pending");
        rd(3'd2, 32'h0, "rst_mask");
        rd(3'd4, 32'h0, "rst_fall_en");
        rd(3'd0, 32'h0, "rst_state");
        chk_irq(1'b1, "rst_irq");

        // rise on bit0: pending and IRQ exactly L edges after the sampling edge
        wr(3'd2, 32'h01);
        inputs[0] = 1'b1;
        steps(L - 1);
        chk_irq(1'b1, "rise_irq_early");
        chk_irq(1'b0, "rise_irq_on_time");
        rd(3'd0, 32'h01, "rise_state");
        rd(3'd1, 32'h01, "rise_pending");
        wr(3'd1, 32'h01);
        chk_irq(1'b1, "w1c_irq");
        rd(3'd1, 32'h0, "w1c_pending");

        // glitch rejection
`ifdef USER_INPUT_DEBOUNCE_EN
        inputs[3] = 1'b1;
        steps(3);
        inputs[3] = 1'b0;
        steps(12);
        rd(3'd0, 32'h01, "glitch3_state");
        rd(3'd1, 32'h0, "glitch3_pending");
`endif
        inputs[3] = 1'b1;
        steps(4);
        inputs[3] = 1'b0;
        steps(12);
        rd(3'd1, 32'h08, "pulse4_pending");
        rd(3'd0, 32'h01, "pulse4_state");
        wr(3'd1, 32'h08);

        // fall-only on bit2
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h04);
        wr(3'd2, 32'h04);
        inputs[2] = 1'b1;
        steps(10);
        rd(3'd1, 32'h0, "fall_no_rise");
        chk_irq(1'b1, "fall_no_rise_irq");
        inputs[2] = 1'b0;
        steps(10);
        rd(3'd1, 32'h04, "fall_pending");
        chk_irq(1'b0, "fall_irq");
        wr(3'd1, 32'h04);
        chk_irq(1'b1, "fall_clr_irq");

        // set wins over W1C on the same edge
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h02);
        inputs[1] = 1'b1;
        steps(L);
        wr(3'd1, 32'h02);
        rd(3'd1, 32'h02, "collide_pending");
        chk_irq(1'b0, "collide_irq");

        // unmask an already-pending bit
        wr(3'd2, 32'h0);
        chk_irq(1'b1, "masked_irq");
        wr(3'd2, 32'h02);
        chk_irq(1'b0, "unmask_irq");

        // same-cycle read and write returns the pre-write value
        rdwr(3'd1, 32'h02, 32'h02, "rdwr_pending_old");
        rd(3'd1, 32'h0, "rdwr_pending_new");
        chk_irq(1'b1, "rdwr_irq");

        // upper bits and unmapped addresses
        wr(3'd2, 32'hFFFF_FF02);
        rd(3'd2, 32'h02, "mask_hi_bits");
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'h0, "addr5");
        rd(3'd7, 32'h0, "addr7");

        // reset mid-operation with inputs 0,1 high
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        rd(3'd1, 32'h0, "mid_rst_pending");
        rd(3'd2, 32'h0, "mid_rst_mask");
        rd(3'd3, 32'hFF, "mid_rst_rise_en");
        chk_irq(1'b1, "mid_rst_irq");
        steps(10);
        rd(3'd1, 32'h03, "post_rst_rise");
        rd(3'd0, 32'h03, "post_rst_state");
        chk_irq(1'b1, "post_rst_irq_masked");

        steps(4);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
